// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared core constants for decode, issue and the register file
package regfile_scoreboard_pkg;
   localparam int DATA_WIDTH_DEF     = 32;
   localparam int REGISTERS_DEF      = 32;
   localparam int LOG2_REGISTERS_DEF = 5;
   localparam int READ_PORTS_DEF     = 2;
   localparam int READ_PORTS_MAX     = 4;
   localparam int ZERO_REG_DEF       = 1;
   localparam int BYPASS_DEF         = 1;
endpackage

// File: rtl/regfile_busy_table.sv
// regfile_busy_table: per-register pending bits with reserve/write arbitration and a pending counter
// ports: clk, rst (sync, active high); rsv_en/rsv_addr set a bit; wr_en/wr_addr clear a bit;
//        busy = current pending bits; pending_cnt = number of set bits
module regfile_busy_table
   import regfile_scoreboard_pkg::*;
#(
   parameter int REGISTERS      = REGISTERS_DEF,
   parameter int LOG2_REGISTERS = LOG2_REGISTERS_DEF
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rsv_en,
   input  logic [LOG2_REGISTERS-1:0] rsv_addr,
   input  logic                      wr_en,
   input  logic [LOG2_REGISTERS-1:0] wr_addr,
   output logic [REGISTERS-1:0]      busy,
   output logic [LOG2_REGISTERS:0]   pending_cnt
);
   logic [REGISTERS-1:0] busy_nx;
   logic set, clr;
   // a write to the register being reserved this cycle leaves it busy, so it never decrements
   assign set = rsv_en && !busy[rsv_addr];
   assign clr = wr_en && busy[wr_addr] && !(rsv_en && rsv_addr == wr_addr);
   always_comb begin
      busy_nx = busy;
      if (wr_en) busy_nx[wr_addr] = 1'b0;
      if (rsv_en) busy_nx[rsv_addr] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         busy        <= '0;
         pending_cnt <= '0;
      end else begin
         busy        <= busy_nx;
         pending_cnt <= pending_cnt + {{LOG2_REGISTERS{1'b0}}, set} - {{LOG2_REGISTERS{1'b0}}, clr};
      end
   end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write bypass and a pending-write scoreboard
// ports: clk, rst (sync, active high); rd_addr/rd_data/rd_busy per read port (combinational);
//        wr_en/wr_addr/wr_data write and clear pending; rsv_en/rsv_addr mark pending;
//        rsv_busy = rsv_addr already pending; pending_cnt = pending register count
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int REGISTERS      = REGISTERS_DEF,
   parameter int LOG2_REGISTERS = LOG2_REGISTERS_DEF,
   parameter int READ_PORTS     = READ_PORTS_DEF,
   parameter int ZERO_REG       = ZERO_REG_DEF,
   parameter int BYPASS         = BYPASS_DEF
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [READ_PORTS*LOG2_REGISTERS-1:0] rd_addr,
   output logic [READ_PORTS*DATA_WIDTH-1:0]     rd_data,
   output logic [READ_PORTS-1:0]                rd_busy,
   input  logic                                 wr_en,
   input  logic [LOG2_REGISTERS-1:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0]                wr_data,
   input  logic                                 rsv_en,
   input  logic [LOG2_REGISTERS-1:0]            rsv_addr,
   output logic                                 rsv_busy,
   output logic [LOG2_REGISTERS:0]              pending_cnt
);
   logic [DATA_WIDTH-1:0] regs [REGISTERS];
   logic [REGISTERS-1:0]  busy;
   logic wr_ok, rsv_ok;
   // accesses to the hardwired zero register are dropped before they reach any state
   assign wr_ok  = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
   assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REGISTERS; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end
   regfile_busy_table #(
      .REGISTERS(REGISTERS),
      .LOG2_REGISTERS(LOG2_REGISTERS)
   ) u_busy (
      .clk(clk),
      .rst(rst),
      .rsv_en(rsv_ok),
      .rsv_addr(rsv_addr),
      .wr_en(wr_ok),
      .wr_addr(wr_addr),
      .busy(busy),
      .pending_cnt(pending_cnt)
   );
   assign rsv_busy = busy[rsv_addr];
   for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
      logic [LOG2_REGISTERS-1:0] a;
      logic zero, hit;
      assign a    = rd_addr[p*LOG2_REGISTERS +: LOG2_REGISTERS];
      assign zero = ZERO_REG != 0 && a == '0;
      assign hit  = BYPASS != 0 && wr_ok && wr_addr == a;
      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = zero ? '0 : hit ? wr_data : regs[a];
      // a forwarded write also forwards its busy clear, unless a same-cycle reservation re-arms it
      assign rd_busy[p] = !zero && !(hit && !(rsv_ok && rsv_addr == a)) && busy[a];
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random checks of bypass and non-bypass builds against a reference model
module tb_regfile_scoreboard;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, wr_en, rsv_en;
   logic [4:0]  wr_addr, rsv_addr;
   logic [31:0] wr_data;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data_b, rd_data_n;
   logic [1:0]  rd_busy_b, rd_busy_n;
   logic        rsv_busy_b, rsv_busy_n;
   logic [5:0]  cnt_b, cnt_n;
   int passed = 0, total = 0;
   logic [31:0] m_regs [32];
   bit   [31:0] m_busy;

   regfile_scoreboard #(.BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .rsv_busy(rsv_busy_b), .pending_cnt(cnt_b));
   regfile_scoreboard #(.BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .rsv_busy(rsv_busy_n), .pending_cnt(cnt_n));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp && wr_en && wr_addr == a) return wr_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a, input bit byp);
      if (a == 0) return 1'b0;
      if (byp && wr_en && wr_addr == a && !(rsv_en && rsv_addr == a)) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic cycle();
      @(negedge clk);
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            logic [4:0] a;
            a = rd_addr[p*5 +: 5];
            chk($sformatf("rd_data_byp[%0d]", p), rd_data_b[p*32 +: 32], exp_rd(a, 1));
            chk($sformatf("rd_data_nob[%0d]", p), rd_data_n[p*32 +: 32], exp_rd(a, 0));
            chk($sformatf("rd_busy_byp[%0d]", p), 32'(rd_busy_b[p]), 32'(exp_busy(a, 1)));
            chk($sformatf("rd_busy_nob[%0d]", p), 32'(rd_busy_n[p]), 32'(exp_busy(a, 0)));
         end
         chk("rsv_busy_byp", 32'(rsv_busy_b), 32'(m_busy[rsv_addr]));
         chk("rsv_busy_nob", 32'(rsv_busy_n), 32'(m_busy[rsv_addr]));
         chk("pending_byp", 32'(cnt_b), $countones(m_busy));
         chk("pending_nob", 32'(cnt_n), $countones(m_busy));
      end
      @(posedge clk);
      if (rst) begin
         m_busy = '0;
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      end else begin
         if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
         end
         if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      rst = 1'b0;
      wr_en = 1'b0;
      rsv_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_busy = '0;
      rst = 1'b1; wr_en = 1'b1; rsv_en = 1'b1; wr_addr = 5'd9; rsv_addr = 5'd9;
      wr_data = 32'hA5A5A5A5; rd_addr = '0;
      cycle();
      cycle();
      idle();
      for (int a = 0; a < 32; a++) begin
         rd_addr = {5'(a), 5'(a)};
         cycle();
      end
      #1;
      chk("reset_pending", 32'(cnt_b), 32'd0);
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
      rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr = '0;
      #1;
      chk("zero_rd", rd_data_b[31:0], 32'h0);
      chk("zero_busy", 32'(rd_busy_b[0]), 32'd0);
      cycle();
      idle();
      #1;
      chk("zero_rd_after", rd_data_b[31:0], 32'h0);
      chk("zero_pending", 32'(cnt_b), 32'd0);
      rsv_en = 1'b1; rsv_addr = 5'd5;
      cycle();
      idle();
      #1;
      chk("rsv5_pending", 32'(cnt_b), 32'd1);
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd5, 5'd5};
      #1;
      chk("byp5_rd", rd_data_b[31:0], 32'hDEADBEEF);
      chk("byp5_busy", 32'(rd_busy_b[0]), 32'd0);
      chk("nob5_rd", rd_data_n[31:0], 32'h0);
      chk("nob5_busy", 32'(rd_busy_n[0]), 32'd1);
      cycle();
      idle();
      #1;
      chk("wr5_pending", 32'(cnt_b), 32'd0);
      rsv_en = 1'b1; rsv_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
      cycle();
      idle();
      rd_addr = {5'd7, 5'd7};
      #1;
      chk("same7_rd", rd_data_b[31:0], 32'h11);
      chk("same7_busy", 32'(rd_busy_b[0]), 32'd1);
      chk("same7_pending", 32'(cnt_b), 32'd1);
      for (int a = 1; a < 32; a++) begin
         rsv_en = 1'b1; rsv_addr = 5'(a);
         cycle();
      end
      idle();
      #1;
      chk("all_pending", 32'(cnt_b), 32'd31);
      rsv_en = 1'b1; rsv_addr = 5'd3;
      #1;
      chk("rerv3_rsv_busy", 32'(rsv_busy_b), 32'd1);
      cycle();
      idle();
      #1;
      chk("rerv3_pending", 32'(cnt_b), 32'd31);
      rst = 1'b1;
      cycle();
      idle();
      #1;
      chk("rst_pending_byp", 32'(cnt_b), 32'd0);
      chk("rst_pending_nob", 32'(cnt_n), 32'd0);
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55; rd_addr = {5'd2, 5'd2};
      #1;
      chk("nob2_rd_now", rd_data_n[31:0], 32'h0);
      chk("byp2_rd_now", rd_data_b[31:0], 32'h55);
      cycle();
      idle();
      #1;
      chk("nob2_rd_next", rd_data_n[31:0], 32'h55);
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         wr_en = 1'($urandom);
         wr_addr = 5'($urandom);
         wr_data = $urandom;
         rsv_en = 1'($urandom);
         rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
         for (int p = 0; p < 2; p++)
            rd_addr[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
         cycle();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
